dp_bank_ctrl: RTL and testbench

DP_BANK_CTRL -- requirements
Module: dp_bank_ctrl

---
 rtl/dp_bank_ctrl.sv | 130 +++++++++++++
 tb/tb_dp_bank_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_bank_ctrl.sv
// Bank rotation controller for a DP fill array with a shared traceback engine.
// Filled banks queue for traceback; the fill side stalls when the next bank is still owned.
module dp_bank_ctrl #(
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = 1,
  parameter int TBV_PULSE = 3
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic                 new_seq,
  input  logic                 tb_busy,
  input  logic                 tb_done,
  output logic [BANK_W-1:0]    fill_bank,
  output logic                 fill_active,
  output logic                 stall,
  output logic                 tb_valid,
  output logic [BANK_W-1:0]    tb_bank,
  output logic [NUM_BANKS-1:0] bank_full,
  output logic                 overflow
);

  typedef enum logic [1:0] {IDLE, FILL, STALL} state_t;

  localparam logic [BANK_W-1:0] LAST = BANK_W'(NUM_BANKS - 1);

  state_t state;
  logic q, qq, ev;
  logic [BANK_W-1:0] fifo [NUM_BANKS];
  logic [BANK_W-1:0] rd_ptr, wr_ptr;
  logic [BANK_W:0] cnt;
  logic in_flight;
  logic [3:0] pcnt;

  logic [BANK_W-1:0] nxt;
  logic rel, push, pop;
  logic [NUM_BANKS-1:0] rel_mask, set_mask, full_rel;

  function automatic logic [BANK_W-1:0] inc(input logic [BANK_W-1:0] p);
    return (p == LAST) ? '0 : p + BANK_W'(1);
  endfunction

  assign nxt      = inc(fill_bank);
  assign rel      = tb_done & in_flight;
  assign push     = (state == FILL) & ev;
  assign pop      = (cnt != '0) & ~in_flight & ~tb_busy;
  assign rel_mask = rel ? (NUM_BANKS'(1) << tb_bank) : '0;
  assign set_mask = push ? (NUM_BANKS'(1) << fill_bank) : '0;
  // release is applied before the advance decision looks at the next bank
  assign full_rel = bank_full & ~rel_mask;

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= fill_bank;
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state       <= IDLE;
      q           <= 1'b0;
      qq          <= 1'b0;
      ev          <= 1'b0;
      fill_bank   <= '0;
      fill_active <= 1'b0;
      stall       <= 1'b0;
      tb_valid    <= 1'b0;
      tb_bank     <= '0;
      bank_full   <= '0;
      overflow    <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      cnt         <= '0;
      in_flight   <= 1'b0;
      pcnt        <= '0;
    end else begin
      q         <= new_seq;
      qq        <= q;
      ev        <= q & ~qq;
      bank_full <= full_rel | set_mask;
      cnt       <= cnt + {{BANK_W{1'b0}}, push} - {{BANK_W{1'b0}}, pop};
      if (push) wr_ptr <= inc(wr_ptr);

      if (pop) begin
        tb_bank   <= fifo[rd_ptr];
        rd_ptr    <= inc(rd_ptr);
        in_flight <= 1'b1;
        pcnt      <= 4'(TBV_PULSE);
        tb_valid  <= 1'b1;
      end else if (rel) begin
        in_flight <= 1'b0;
        pcnt      <= '0;
        tb_valid  <= 1'b0;
      end else if (pcnt != '0) begin
        pcnt     <= pcnt - 4'd1;
        tb_valid <= (pcnt > 4'd1);
      end

      unique case (state)
        IDLE: begin
          if (ev) begin
            state       <= FILL;
            fill_bank   <= '0;
            fill_active <= 1'b1;
          end
        end
        FILL: begin
          if (ev) begin
            if (!full_rel[nxt]) begin
              fill_bank <= nxt;
            end else begin
              state       <= STALL;
              fill_active <= 1'b0;
              stall       <= 1'b1;
            end
          end
        end
        STALL: begin
          if (!full_rel[nxt]) begin
            state       <= FILL;
            fill_bank   <= nxt;
            fill_active <= 1'b1;
            stall       <= 1'b0;
          end else if (ev) begin
            overflow <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_bank_ctrl.sv
// Bench for dp_bank_ctrl: two instances (2 banks / 3 banks) checked every cycle
// against a bank-ownership model, plus directed literal checkpoints.
module tb_dp_bank_ctrl;

  logic clk;
  logic reset_i;
  logic ns0, bz0, dn0;
  logic ns1, bz1, dn1;
  logic       fb0, fa0, st0, tv0, tb0, ov0;
  logic [1:0] bf0;
  logic [1:0] fb1, tb1;
  logic       fa1, st1, tv1, ov1;
  logic [2:0] bf1;

  int vecs = 0;
  int errs = 0;
  bit auto1 = 0;
  int tblog[$];

  dp_bank_ctrl #(.NUM_BANKS(2), .BANK_W(1), .TBV_PULSE(3)) dut0 (
    .clk(clk), .reset_i(reset_i), .new_seq(ns0), .tb_busy(bz0), .tb_done(dn0),
    .fill_bank(fb0), .fill_active(fa0), .stall(st0), .tb_valid(tv0),
    .tb_bank(tb0), .bank_full(bf0), .overflow(ov0)
  );

  dp_bank_ctrl #(.NUM_BANKS(3), .BANK_W(2), .TBV_PULSE(2)) dut1 (
    .clk(clk), .reset_i(reset_i), .new_seq(ns1), .tb_busy(bz1), .tb_done(dn1),
    .fill_bank(fb1), .fill_active(fa1), .stall(st1), .tb_valid(tv1),
    .tb_bank(tb1), .bank_full(bf1), .overflow(ov1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Banks are owned either by the filler, by the pending set (ordered by
  // push sequence number), or by traceback; sequence events are the
  // 0->1 transitions of new_seq, taking effect two edges after sampling.
  int m_mode [2];
  int m_fb   [2];
  int m_fa   [2];
  int m_st   [2];
  int m_ov   [2];
  int m_infl [2];
  int m_tbk  [2];
  int m_age  [2];
  int m_ctr  [2];
  bit m_full [2][8];
  bit m_pend [2][8];
  int m_seq  [2][8];
  bit s1 [2];
  bit s2 [2];
  bit s3 [2];

  function automatic int nb(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int tbv(input int k);
    return (k == 0) ? 3 : 2;
  endfunction

  function automatic int full_word(input int k);
    int w = 0;
    for (int b = 0; b < nb(k); b++) if (m_full[k][b]) w += (1 << b);
    return w;
  endfunction

  function automatic int pend_count(input int k);
    int c = 0;
    for (int b = 0; b < nb(k); b++) if (m_pend[k][b]) c++;
    return c;
  endfunction

  function automatic int exp_tv(input int k);
    return (m_infl[k] != 0 && m_age[k] < tbv(k)) ? 1 : 0;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_fb[k] = 0; m_fa[k] = 0; m_st[k] = 0; m_ov[k] = 0;
      m_infl[k] = 0; m_tbk[k] = 0; m_age[k] = 0; m_ctr[k] = 0;
      s1[k] = 0; s2[k] = 0; s3[k] = 0;
      for (int b = 0; b < 8; b++) begin
        m_full[k][b] = 0; m_pend[k][b] = 0; m_seq[k][b] = 0;
      end
    end
  endtask

  task automatic m_step(input int k, input bit ns, input bit busy, input bit done);
    int n, nxt, pick;
    bit ev;
    n = nb(k);
    ev = s2[k] && !s3[k];
    s3[k] = s2[k]; s2[k] = s1[k]; s1[k] = ns;
    pick = -1;
    for (int b = 0; b < n; b++)
      if (m_pend[k][b] && (pick < 0 || m_seq[k][b] < m_seq[k][pick])) pick = b;
    if (done && m_infl[k] != 0) begin
      m_full[k][m_tbk[k]] = 0;
      m_infl[k] = 0;
    end else if (m_infl[k] == 0 && !busy && pick >= 0) begin
      m_pend[k][pick] = 0;
      m_tbk[k] = pick;
      m_infl[k] = 1;
      m_age[k] = 0;
    end else if (m_age[k] < 100) begin
      m_age[k]++;
    end
    nxt = (m_fb[k] + 1) % n;
    case (m_mode[k])
      0: if (ev) begin m_mode[k] = 1; m_fb[k] = 0; m_fa[k] = 1; end
      1: if (ev) begin
        m_full[k][m_fb[k]] = 1;
        m_pend[k][m_fb[k]] = 1;
        m_seq[k][m_fb[k]] = m_ctr[k]++;
        if (!m_full[k][nxt]) m_fb[k] = nxt;
        else begin m_mode[k] = 2; m_fa[k] = 0; m_st[k] = 1; end
      end
      default: begin
        if (!m_full[k][nxt]) begin
          m_mode[k] = 1; m_fb[k] = nxt; m_fa[k] = 1; m_st[k] = 0;
        end else if (ev) m_ov[k] = 1;
      end
    endcase
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_i);
      if (!reset_i) m_reset();
      else begin
        m_step(0, ns0, bz0, dn0);
        m_step(1, ns1, bz1, dn1);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("m0_fill_bank", fb0, m_fb[0]);
    chk("m0_fill_active", fa0, m_fa[0]);
    chk("m0_stall", st0, m_st[0]);
    chk("m0_tb_valid", tv0, exp_tv(0));
    chk("m0_tb_bank", tb0, m_tbk[0]);
    chk("m0_bank_full", bf0, full_word(0));
    chk("m0_overflow", ov0, m_ov[0]);
    chk("m0_queue_cnt", dut0.cnt, pend_count(0));
    chk("m1_fill_bank", fb1, m_fb[1]);
    chk("m1_fill_active", fa1, m_fa[1]);
    chk("m1_stall", st1, m_st[1]);
    chk("m1_tb_valid", tv1, exp_tv(1));
    chk("m1_tb_bank", tb1, m_tbk[1]);
    chk("m1_bank_full", bf1, full_word(1));
    chk("m1_overflow", ov1, m_ov[1]);
    chk("m1_queue_cnt", dut1.cnt, pend_count(1));
  end

  // traceback responder for the 3-bank instance
  initial begin
    bit prev = 0;
    dn1 = 0;
    forever begin
      @(posedge clk); #2;
      if (tv1 && !prev) tblog.push_back(int'(tb1));
      prev = tv1;
      dn1 = auto1 && tv1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic set_ns(input int k, input logic v);
    if (k == 0) ns0 = v; else ns1 = v;
  endtask

  // new_seq high for two samples, then low; returns just after the edge
  // where the resulting sequence event takes effect
  task automatic rise(input int k, input bit with_done);
    set_ns(k, 1'b1);
    cyc(2);
    set_ns(k, 1'b0);
    if (with_done) dn0 = 1'b1;
    cyc(1);
    dn0 = 1'b0;
  endtask

  initial begin
    int fbseq [7];
    int tbord [6];
    fbseq = '{0, 1, 2, 0, 1, 2, 0};
    tbord = '{0, 1, 2, 0, 1, 2};
    reset_i = 1'b0;
    ns0 = 0; bz0 = 0; dn0 = 0;
    ns1 = 0; bz1 = 0;
    cyc(3);
    chk("rst_fill_active", fa0, 0);
    chk("rst_bank_full", bf0, 0);
    reset_i = 1'b1;
    cyc(2);

    // first rise: takes effect two edges after the first high sample
    ns0 = 1'b1;
    cyc(2);
    chk("lat_not_yet", fa0, 0);
    ns0 = 1'b0;
    cyc(1);
    chk("r1_fill_active", fa0, 1);
    chk("r1_fill_bank", fb0, 0);

    rise(0, 0);
    chk("r2_bank_full", bf0, 2'b01);
    chk("r2_fill_bank", fb0, 1);
    chk("r2_tv_early", tv0, 0);
    cyc(1);
    chk("r2_tv_c1", tv0, 1);
    chk("r2_tb_bank", tb0, 0);
    cyc(1);
    chk("r2_tv_c2", tv0, 1);
    cyc(1);
    chk("r2_tv_c3", tv0, 1);
    cyc(1);
    chk("r2_tv_end", tv0, 0);

    rise(0, 0);
    chk("r3_bank_full", bf0, 2'b11);
    chk("r3_stall", st0, 1);
    chk("r3_fill_active", fa0, 0);
    chk("r3_fill_bank", fb0, 1);
    rise(0, 0);
    chk("r4_overflow", ov0, 1);

    dn0 = 1'b1;
    cyc(1);
    dn0 = 1'b0;
    chk("rel_bank_full", bf0, 2'b10);
    chk("rel_fill_bank", fb0, 0);
    chk("rel_stall", st0, 0);
    chk("rel_fill_active", fa0, 1);
    cyc(1);
    chk("disp2_tv", tv0, 1);
    chk("disp2_tb_bank", tb0, 1);

    // reset in the middle of a traceback pulse
    reset_i = 1'b0;
    #1;
    chk("arst_tv", tv0, 0);
    chk("arst_tb_bank", tb0, 0);
    chk("arst_bank_full", bf0, 0);
    chk("arst_fill_bank", fb0, 0);
    chk("arst_fill_active", fa0, 0);
    chk("arst_overflow", ov0, 0);
    cyc(2);
    reset_i = 1'b1;
    cyc(1);
    dn0 = 1'b1;
    cyc(1);
    dn0 = 1'b0;
    cyc(1);
    chk("post_rst_done_bf", bf0, 0);
    chk("post_rst_done_tv", tv0, 0);

    // stall + sequence event + tb_done on the same edge, dispatch held by busy
    rise(0, 0);
    rise(0, 0);
    rise(0, 0);
    chk("s3_stall", st0, 1);
    bz0 = 1'b1;
    rise(0, 1);
    chk("same_bank_full", bf0, 2'b10);
    chk("same_fill_bank", fb0, 0);
    chk("same_stall", st0, 0);
    chk("same_fill_active", fa0, 1);
    chk("same_overflow", ov0, 0);
    cyc(2);
    chk("busy_tv", tv0, 0);
    bz0 = 1'b0;
    cyc(1);
    chk("unbusy_tv", tv0, 1);
    chk("unbusy_tb_bank", tb0, 1);
    dn0 = 1'b1;
    cyc(1);
    dn0 = 1'b0;
    cyc(2);

    // three banks, traceback answered immediately
    auto1 = 1;
    for (int i = 0; i < 7; i++) begin
      rise(1, 0);
      chk($sformatf("b3_fill_bank_%0d", i), fb1, fbseq[i]);
    end
    cyc(6);
    chk("b3_tb_count", tblog.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("b3_tb_order_%0d", i), (i < tblog.size()) ? tblog[i] : -1, tbord[i]);
    chk("b3_overflow", ov1, 0);
    auto1 = 0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
